// File: rtl/msrv32_bpu.sv
// rtl/msrv32_bpu.sv - branch resolution, 2-bit BHT prediction and statistics for msrv32
module msrv32_bpu #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_in,
    input  logic                valid_in,
    input  logic [4:0]          opcode_6_to_2_in,
    input  logic [2:0]          funct3_in,
    input  logic [XLEN-1:0]     rs1_in,
    input  logic [XLEN-1:0]     rs2_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic                predicted_taken_in,
    input  logic [XLEN-1:0]     lookup_pc_in,
    input  logic                stats_clr_in,
    output logic                predict_taken_out,
    output logic                valid_out,
    output logic                branch_taken_out,
    output logic                mispredict_out,
    output logic [CNT_W-1:0]    branch_count_out,
    output logic [CNT_W-1:0]    mispredict_count_out
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       bht [BHT_ENTRIES];

    logic             is_branch;
    logic             is_jump;
    logic             f3_legal;
    logic             cond;
    logic             taken;
    logic             mispredict;
    logic             bht_upd;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;

    // Bits of the PCs that play no part in indexing.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{pc_in[XLEN-1:IDX_W+2], pc_in[1:0],
                              lookup_pc_in[XLEN-1:IDX_W+2], lookup_pc_in[1:0]};

    assign upd_idx    = pc_in[IDX_W+1:2];
    assign lookup_idx = lookup_pc_in[IDX_W+1:2];

    // Fetch-side lookup reads the table as it stands before this cycle's update.
    assign predict_taken_out = bht[lookup_idx][1];

    // Opcode decode and branch condition evaluation.
    always_comb begin
        is_branch = 1'b0;
        is_jump   = 1'b0;
        f3_legal  = 1'b0;
        cond      = 1'b0;
        case (opcode_6_to_2_in)
            OPC_BRANCH: is_branch = 1'b1;
            OPC_JAL:    is_jump   = 1'b1;
            OPC_JALR:   is_jump   = 1'b1;
            default:    ;
        endcase
        case (funct3_in)
            3'b000: begin f3_legal = 1'b1; cond = (rs1_in == rs2_in); end
            3'b001: begin f3_legal = 1'b1; cond = (rs1_in != rs2_in); end
            3'b100: begin f3_legal = 1'b1; cond = ($signed(rs1_in) <  $signed(rs2_in)); end
            3'b101: begin f3_legal = 1'b1; cond = ($signed(rs1_in) >= $signed(rs2_in)); end
            3'b110: begin f3_legal = 1'b1; cond = (rs1_in <  rs2_in); end
            3'b111: begin f3_legal = 1'b1; cond = (rs1_in >= rs2_in); end
            default: ;
        endcase
        taken = is_jump | (is_branch & f3_legal & cond);
    end

    // A non-control instruction guessed taken also counts as a mispredict.
    assign mispredict = valid_in & (taken != predicted_taken_in);
    assign bht_upd    = valid_in & is_branch & f3_legal;

    // Result pipeline register and saturating BHT update.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            valid_out        <= 1'b0;
            branch_taken_out <= 1'b0;
            mispredict_out   <= 1'b0;
            for (int k = 0; k < BHT_ENTRIES; k++) begin
                bht[k] <= 2'b01;
            end
        end else begin
            valid_out        <= valid_in;
            branch_taken_out <= valid_in & taken;
            mispredict_out   <= mispredict;
            if (bht_upd) begin
                if (cond && bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'b01;
                end else if (!cond && bht[upd_idx] != 2'b00) begin
                    bht[upd_idx] <= bht[upd_idx] - 2'b01;
                end
            end
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in || stats_clr_in) begin
            branch_count_out     <= '0;
            mispredict_count_out <= '0;
        end else begin
            if (bht_upd && branch_count_out != CNT_MAX) begin
                branch_count_out <= branch_count_out + CNT_ONE;
            end
            if (mispredict && mispredict_count_out != CNT_MAX) begin
                mispredict_count_out <= mispredict_count_out + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_msrv32_bpu.sv
// tb/tb_msrv32_bpu.sv - scoreboard bench for msrv32_bpu
module tb_msrv32_bpu;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    localparam logic [4:0] BR   = 5'b11000;
    localparam logic [4:0] JAL  = 5'b11011;
    localparam logic [4:0] JALR = 5'b11001;
    localparam logic [4:0] ALU  = 5'b01100;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             valid_in = 1'b0;
    logic [4:0]       opcode = '0;
    logic [2:0]       funct3 = '0;
    logic [31:0]      rs1 = '0;
    logic [31:0]      rs2 = '0;
    logic [31:0]      pc = '0;
    logic             pred = 1'b0;
    logic [31:0]      lpc = '0;
    logic             clr = 1'b0;
    logic             predict_taken_out;
    logic             valid_out;
    logic             branch_taken_out;
    logic             mispredict_out;
    logic [CNT_W-1:0] branch_count_out;
    logic [CNT_W-1:0] mispredict_count_out;

    msrv32_bpu #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(CNT_W)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .valid_in             (valid_in),
        .opcode_6_to_2_in     (opcode),
        .funct3_in            (funct3),
        .rs1_in               (rs1),
        .rs2_in               (rs2),
        .pc_in                (pc),
        .predicted_taken_in   (pred),
        .lookup_pc_in         (lpc),
        .stats_clr_in         (clr),
        .predict_taken_out    (predict_taken_out),
        .valid_out            (valid_out),
        .branch_taken_out     (branch_taken_out),
        .mispredict_out       (mispredict_out),
        .branch_count_out     (branch_count_out),
        .mispredict_count_out (mispredict_count_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic t;
        logic m;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] mbht [64];
    int         mbr;
    int         mmis;
    int         vectors;
    int         miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_taken(input logic [4:0] o, input logic [2:0] f,
                                               input logic [31:0] a, input logic [31:0] b);
        // returns {legal_branch, taken}
        if (o == JAL || o == JALR) return 2'b01;
        if (o != BR) return 2'b00;
        case (f)
            3'b000: return {1'b1, a == b};
            3'b001: return {1'b1, a != b};
            3'b100: return {1'b1, $signed(a) <  $signed(b)};
            3'b101: return {1'b1, $signed(a) >= $signed(b)};
            3'b110: return {1'b1, a <  b};
            3'b111: return {1'b1, a >= b};
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) mbht[k] = 2'b01;
        mbr  = 0;
        mmis = 0;
    endtask

    // One request cycle: drive, check lookup before the edge, push expectation,
    // advance the model at the edge, then pop and compare the registered outputs.
    task automatic step(input logic v, input logic [4:0] o, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                        input logic pr, input logic [31:0] lp, input logic c, input logic r);
        exp_t       e;
        logic [1:0] lt;
        logic       mis;
        int         i;
        valid_in = v; opcode = o; funct3 = f; rs1 = a; rs2 = b;
        pc = p; pred = pr; lpc = lp; clr = c; rst = r;
        #1;
        chk("predict_pre", {31'b0, predict_taken_out}, {31'b0, mbht[lp[7:2]][1]});
        lt  = model_taken(o, f, a, b);
        mis = v & (lt[0] != pr);
        e.v = r ? 1'b0 : v;
        e.t = r ? 1'b0 : (v & lt[0]);
        e.m = r ? 1'b0 : mis;
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            i = int'(p[7:2]);
            if (v && lt[1]) begin
                if (lt[0] && mbht[i] != 2'b11) mbht[i] = mbht[i] + 2'b01;
                if (!lt[0] && mbht[i] != 2'b00) mbht[i] = mbht[i] - 2'b01;
            end
            if (c) begin
                mbr = 0; mmis = 0;
            end else begin
                if (v && lt[1] && mbr < CMAX) mbr++;
                if (mis && mmis < CMAX) mmis++;
            end
        end
        #1;
        valid_in = 1'b0; clr = 1'b0; rst = 1'b0;
        e = sb.pop_front();
        chk("valid_out", {31'b0, valid_out}, {31'b0, e.v});
        chk("branch_taken_out", {31'b0, branch_taken_out}, {31'b0, e.t});
        chk("mispredict_out", {31'b0, mispredict_out}, {31'b0, e.m});
        chk("branch_count", {28'b0, branch_count_out}, mbr);
        chk("mispredict_count", {28'b0, mispredict_count_out}, mmis);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        @(posedge clk);
        #1;

        // reset, then check everything is cleared
        step(1'b0, ALU, 3'b000, 0, 0, 0, 1'b0, 32'h100, 1'b0, 1'b1);
        step(1'b0, ALU, 3'b000, 0, 0, 0, 1'b0, 32'h100, 1'b0, 1'b0);
        chk("reset_predict", {31'b0, predict_taken_out}, 32'd0);

        // signed vs unsigned compare on the same operands
        step(1'b1, BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("blt_taken", {31'b0, branch_taken_out}, 32'd1);
        chk("blt_mispredict", {31'b0, mispredict_out}, 32'd1);
        step(1'b1, BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("bltu_taken", {31'b0, branch_taken_out}, 32'd0);
        chk("bltu_mispredict", {31'b0, mispredict_out}, 32'd0);

        // remaining conditions, both outcomes
        step(1'b1, BR, 3'b001, 32'd3, 32'd3, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0);
        step(1'b1, BR, 3'b101, 32'h8000_0000, 32'd0, 32'h304, 1'b0, 32'h304, 1'b0, 1'b0);
        step(1'b1, BR, 3'b111, 32'h8000_0000, 32'd0, 32'h308, 1'b1, 32'h308, 1'b0, 1'b0);
        step(1'b1, ALU, 3'b000, 32'd0, 32'd0, 32'h30C, 1'b1, 32'h30C, 1'b0, 1'b0);
        chk("nonctrl_mispredict", {31'b0, mispredict_out}, 32'd1);

        // four taken BEQs at 0x100 from a fresh table
        step(1'b0, ALU, 3'b000, 0, 0, 0, 1'b0, 32'h100, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            step(1'b1, BR, 3'b000, 32'd7, 32'd7, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0);
            chk("beq_predict_after", {31'b0, predict_taken_out}, 32'd1);
        end
        chk("beq_count4", {28'b0, branch_count_out}, 32'd4);
        lpc = 32'h100 + 4 * 64;
        #1;
        chk("alias_predict", {31'b0, predict_taken_out}, 32'd1);

        // same-cycle lookup and update at index 5
        step(1'b1, BR, 3'b000, 32'd1, 32'd1, 32'h14, 1'b0, 32'h14, 1'b0, 1'b0);
        chk("rbw_new_value", {31'b0, predict_taken_out}, 32'd1);

        // jumps and illegal funct3 leave the table alone
        step(1'b1, JAL, 3'b000, 32'd0, 32'd0, 32'h18, 1'b0, 32'h18, 1'b0, 1'b0);
        chk("jal_taken", {31'b0, branch_taken_out}, 32'd1);
        chk("jal_no_bht", {31'b0, predict_taken_out}, 32'd0);
        chk("jal_branch_count", {28'b0, branch_count_out}, 32'd5);
        step(1'b1, JALR, 3'b000, 32'd0, 32'd0, 32'h18, 1'b1, 32'h18, 1'b0, 1'b0);
        step(1'b1, BR, 3'b010, 32'd2, 32'd2, 32'h18, 1'b0, 32'h18, 1'b0, 1'b0);
        step(1'b1, BR, 3'b011, 32'd2, 32'd2, 32'h18, 1'b0, 32'h18, 1'b0, 1'b0);
        chk("illegal_taken", {31'b0, branch_taken_out}, 32'd0);
        chk("illegal_branch_count", {28'b0, branch_count_out}, 32'd5);

        // mispredict counter saturation
        for (int n = 0; n < 20; n++) begin
            step(1'b1, JAL, 3'b000, 32'd0, 32'd0, 32'h40, 1'b0, 32'h40, 1'b0, 1'b0);
        end
        chk("mis_saturate", {28'b0, mispredict_count_out}, 32'd15);

        // clear wins over same-cycle increment
        step(1'b1, JAL, 3'b000, 32'd0, 32'd0, 32'h40, 1'b0, 32'h40, 1'b1, 1'b0);
        chk("clr_priority", {28'b0, mispredict_count_out}, 32'd0);

        // reset with a request in flight
        step(1'b1, BR, 3'b000, 32'd1, 32'd1, 32'h14, 1'b1, 32'h14, 1'b0, 1'b0);
        step(1'b1, JAL, 3'b000, 32'd0, 32'd0, 32'h14, 1'b0, 32'h14, 1'b0, 1'b1);
        chk("reset_drop_valid", {31'b0, valid_out}, 32'd0);
        chk("reset_bht", {31'b0, predict_taken_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
